// File: rtl/cpu_clk_ctrl.sv
// Execution-clock controller for the single-cycle CPU.
// A prescaler derives the timebase tick. The tick drives the 7-seg digit scan,
// the button debouncer and the run-mode step divider. A small FSM turns run
// requests or debounced button presses into one-cycle CPU clock-enable pulses.
module cpu_clk_ctrl #(
  parameter int DIV_COUNT      = 50000,
  parameter int RUN_DIV        = 500,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic        CLK_in,
  input  logic        Reset,
  input  logic        Mode_run,
  input  logic        Step_btn,
  input  logic        Halt,
  output logic        CPU_en,
  output logic        Scan_tick,
  output logic [1:0]  Scan_sel,
  output logic [1:0]  State,
  output logic [15:0] Step_count
);

  localparam int PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int RW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_COUNT - 1);
  localparam logic [RW-1:0] RUN_MAX   = RW'(RUN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_STEP   = 2'b10;
  localparam logic [1:0] S_HALTED = 2'b11;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_scan_sel;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_db_level;
  logic [DW-1:0] r_db_cnt;
  logic [RW-1:0] r_run_cnt;
  logic [1:0]    r_state;
  logic          r_cpu_en;
  logic [15:0]   r_step_count;

  logic          w_tick;
  logic          w_step_req;
  logic          w_run_req;
  logic [1:0]    w_state_next;
  logic          w_en_next;

  // The tick is decoded from the terminal count so it lines up with the wrap.
  assign w_tick = (r_presc == PRESC_MAX);

  // A press is accepted on the tick where the counter would reach the limit
  // with a high sample; that same cycle is the step request.
  assign w_step_req = w_tick && r_sync2 && !r_db_level && (r_db_cnt == DEB_LAST);

  // Run requests only exist while running.
  assign w_run_req = w_tick && (r_state == S_RUN) && (r_run_cnt == RUN_MAX);

  // Free-running timebase prescaler, independent of the FSM state.
  always_ff @(posedge CLK_in or negedge Reset) begin
    if (!Reset)      r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  // Digit-scan select advances after every tick, even when halted.
  always_ff @(posedge CLK_in or negedge Reset) begin
    if (!Reset)      r_scan_sel <= 2'd0;
    else if (w_tick) r_scan_sel <= r_scan_sel + 2'd1;
  end

  // Two-flop synchroniser for the raw push-button.
  always_ff @(posedge CLK_in or negedge Reset) begin
    if (!Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= Step_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: a new level must be seen on consecutive ticks before it is taken.
  always_ff @(posedge CLK_in or negedge Reset) begin
    if (!Reset) begin
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
    end else if (w_tick) begin
      if (r_sync2 != r_db_level) begin
        if (r_db_cnt == DEB_LAST) begin
          r_db_level <= r_sync2;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DW'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Run-mode divider; held at zero outside RUN so every entry starts fresh.
  always_ff @(posedge CLK_in or negedge Reset) begin
    if (!Reset)                r_run_cnt <= '0;
    else if (r_state != S_RUN) r_run_cnt <= '0;
    else if (w_tick)           r_run_cnt <= (r_run_cnt == RUN_MAX) ? '0 : r_run_cnt + RW'(1);
  end

  // Next-state and enable decode. Halt is checked first so a coincident
  // request never produces a pulse; the enable is never requested on the
  // cycle it is already high, which keeps pulses separated.
  always_comb begin
    w_state_next = r_state;
    w_en_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Mode_run)        w_state_next = S_RUN;
        else if (w_step_req) w_state_next = S_STEP;
      end
      S_RUN: begin
        if (Halt)                        w_state_next = S_HALTED;
        else if (!Mode_run)              w_state_next = S_IDLE;
        else if (w_run_req && !r_cpu_en) w_en_next    = 1'b1;
      end
      S_STEP: begin
        // First STEP cycle schedules the pulse; the pulse cycle returns to IDLE.
        if (Halt)           w_state_next = S_HALTED;
        else if (!r_cpu_en) w_en_next    = 1'b1;
        else                w_state_next = S_IDLE;
      end
      S_HALTED: begin
        if (w_step_req && !Halt) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, enable pulse and issued-step counter registers.
  always_ff @(posedge CLK_in or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_cpu_en     <= 1'b0;
      r_step_count <= 16'h0000;
    end else begin
      r_state  <= w_state_next;
      r_cpu_en <= w_en_next;
      if (r_cpu_en) r_step_count <= r_step_count + 16'd1;
    end
  end

  assign CPU_en     = r_cpu_en;
  assign Scan_tick  = w_tick;
  assign Scan_sel   = r_scan_sel;
  assign State      = r_state;
  assign Step_count = r_step_count;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl with a small timebase (DIV_COUNT=4, RUN_DIV=2,
// DEBOUNCE_TICKS=3). Expected CPU_en pulses (cycle, Step_count) are queued by
// the stimulus; an independent monitor pops one entry for every pulse seen.
module tb_cpu_clk_ctrl;

  localparam int DIV  = 4;
  localparam int RDIV = 2;
  localparam int DEB  = 3;

  logic        CLK_in   = 1'b0;
  logic        Reset    = 1'b0;
  logic        Mode_run = 1'b0;
  logic        Step_btn = 1'b0;
  logic        Halt     = 1'b0;
  logic        CPU_en;
  logic        Scan_tick;
  logic [1:0]  Scan_sel;
  logic [1:0]  State;
  logic [15:0] Step_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
  } pulse_t;

  pulse_t exp_q[$];

  cpu_clk_ctrl #(
    .DIV_COUNT     (DIV),
    .RUN_DIV       (RDIV),
    .DEBOUNCE_TICKS(DEB)
  ) dut (
    .CLK_in    (CLK_in),
    .Reset     (Reset),
    .Mode_run  (Mode_run),
    .Step_btn  (Step_btn),
    .Halt      (Halt),
    .CPU_en    (CPU_en),
    .Scan_tick (Scan_tick),
    .Scan_sel  (Scan_sel),
    .State     (State),
    .Step_count(Step_count)
  );

  always #5 CLK_in = ~CLK_in;

  // Cycle index since the last reset release; cycle k is the k-th period after it.
  always @(posedge CLK_in or negedge Reset) begin
    if (!Reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic to_cycle(input int k);
    while (cyc < k) @(negedge CLK_in);
  endtask

  task automatic expect_pulse(input int c, input logic [15:0] n);
    pulse_t p;
    p.cyc = c;
    p.cnt = n;
    exp_q.push_back(p);
  endtask

  // Monitor: every CPU_en pulse must match the head of the expectation queue.
  initial begin : monitor
    logic   prev_en;
    pulse_t p;
    prev_en = 1'b0;
    forever begin
      @(negedge CLK_in);
      if (Reset && CPU_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cpu_en: got pulse at cycle %0d count %0h, expected none", cyc, Step_count);
        end else begin
          p = exp_q.pop_front();
          chk("pulse_cycle", 32'(cyc), 32'(p.cyc));
          chk("pulse_count", {16'h0, Step_count}, {16'h0, p.cnt});
        end
        chk("pulse_not_back_to_back", {31'h0, prev_en}, 32'h0);
        chk("pulse_state_active", {31'h0, (State == 2'b01) || (State == 2'b10)}, 32'h1);
      end
      prev_en = Reset & CPU_en;
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected end before 50000 time units");
    $fatal(1);
  end

  initial begin : stimulus
    int          tick_cyc[5];
    logic [1:0]  sel_seq[6];
    logic        hit;
    tick_cyc = '{3, 7, 11, 15, 19};
    sel_seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset mid-count: run briefly in RUN mode, then assert reset at cycle 7.
    Mode_run = 1'b1;
    repeat (3) @(negedge CLK_in);
    Reset = 1'b1;
    to_cycle(7);
    chk("pre_reset_scan_tick", {31'h0, Scan_tick}, 32'h1);
    chk("pre_reset_scan_sel", {30'h0, Scan_sel}, 32'h1);
    chk("pre_reset_state", {30'h0, State}, 32'h1);
    #2 Reset = 1'b0;
    #1;
    chk("reset_cpu_en", {31'h0, CPU_en}, 32'h0);
    chk("reset_scan_tick", {31'h0, Scan_tick}, 32'h0);
    chk("reset_scan_sel", {30'h0, Scan_sel}, 32'h0);
    chk("reset_state", {30'h0, State}, 32'h0);
    chk("reset_step_count", {16'h0, Step_count}, 32'h0);
    Mode_run = 1'b0;
    @(negedge CLK_in);
    Reset = 1'b1;

    // Prescaler wrap and digit scan over 20 cycles after release.
    for (int k = 0; k <= 20; k++) begin
      to_cycle(k);
      if (k < 20) begin
        hit = 1'b0;
        foreach (tick_cyc[j]) if (tick_cyc[j] == k) hit = 1'b1;
        chk($sformatf("scan_tick_c%0d", k), {31'h0, Scan_tick}, {31'h0, hit});
      end
      if (k % 4 == 0) chk($sformatf("scan_sel_c%0d", k), {30'h0, Scan_sel}, {30'h0, sel_seq[k / 4]});
    end

    // Debounce in step mode: bounce on alternate ticks, then hold high.
    // Acceptance at tick 51 -> STEP at 52 -> pulse at 53 -> IDLE at 54.
    expect_pulse(53, 16'h0000);
    to_cycle(24); Step_btn = 1'b1;
    to_cycle(28); Step_btn = 1'b0;
    to_cycle(32); Step_btn = 1'b1;
    to_cycle(36); Step_btn = 1'b0;
    to_cycle(40); Step_btn = 1'b1;
    to_cycle(51); chk("dbnc_state_before", {30'h0, State}, 32'h0);
    to_cycle(52); chk("dbnc_state_step", {30'h0, State}, 32'h2);
    to_cycle(54); chk("dbnc_state_idle", {30'h0, State}, 32'h0);
    chk("dbnc_step_count", {16'h0, Step_count}, 32'h1);
    to_cycle(56); Step_btn = 1'b0;

    // Run mode: RUN from cycle 69, pulses every 8 cycles starting at 76.
    for (int i = 0; i < 5; i++) expect_pulse(76 + 8 * i, 16'(1 + i));
    to_cycle(68); Mode_run = 1'b1;
    to_cycle(69); chk("run_state", {30'h0, State}, 32'h1);
    to_cycle(110); Mode_run = 1'b0;
    to_cycle(111); chk("run_exit_state", {30'h0, State}, 32'h0);
    chk("run_step_count", {16'h0, Step_count}, 32'h6);

    // Halt on the run_req cycle (tick 139): no pulse, HALTED until a press.
    to_cycle(132); Mode_run = 1'b1;
    to_cycle(139); Halt = 1'b1;
    to_cycle(140); chk("halt_state", {30'h0, State}, 32'h3);
    to_cycle(150); chk("halt_state_held", {30'h0, State}, 32'h3);
    chk("halt_step_count", {16'h0, Step_count}, 32'h6);
    Mode_run = 1'b0;
    to_cycle(152); Halt = 1'b0; Step_btn = 1'b1;
    to_cycle(163); chk("halt_before_exit", {30'h0, State}, 32'h3);
    to_cycle(164); chk("halt_exit_idle", {30'h0, State}, 32'h0);
    Step_btn = 1'b0;
    to_cycle(166); chk("halt_exit_stays_idle", {30'h0, State}, 32'h0);

    // Halt and Mode_run falling together: HALTED wins.
    to_cycle(176); Mode_run = 1'b1;
    to_cycle(180); Mode_run = 1'b0; Halt = 1'b1;
    to_cycle(181); chk("halt_vs_mode_state", {30'h0, State}, 32'h3);
    to_cycle(184); Halt = 1'b0; Step_btn = 1'b1;
    to_cycle(195); chk("halt2_before_exit", {30'h0, State}, 32'h3);
    to_cycle(196); chk("halt2_exit_idle", {30'h0, State}, 32'h0);
    Step_btn = 1'b0;

    // Counter wrap: preload near the top, then three run pulses.
    to_cycle(208); force dut.r_step_count = 16'hFFFE;
    to_cycle(209); release dut.r_step_count;
    to_cycle(210); chk("wrap_preload", {16'h0, Step_count}, 32'hFFFE);
    expect_pulse(220, 16'hFFFE);
    expect_pulse(228, 16'hFFFF);
    expect_pulse(236, 16'h0000);
    to_cycle(212); Mode_run = 1'b1;
    to_cycle(221); chk("wrap_ffff", {16'h0, Step_count}, 32'hFFFF);
    to_cycle(229); chk("wrap_zero", {16'h0, Step_count}, 32'h0000);
    to_cycle(237); chk("wrap_one", {16'h0, Step_count}, 32'h0001);
    to_cycle(238); Mode_run = 1'b0;

    to_cycle(250);
    chk("pending_pulses", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
